simon_game_core: RTL and testbench
==================================

# simon_game_core

Game engine for the Simon Says design. It sits directly downstream of the free-running 8-bit counter. At `start` it captures the counter value as a seed and expands it with an LFSR into a colour sequence. It then plays the sequence on four LEDs, one step longer each round, and checks the player's debounced button presses against it until the player wins or loses.

## Interface
Parameters:
- `MAX_LEN`, 16: sequence length that wins the game (legal range 2..31).
- `ON_TICKS`, 4: number of `tick` strobes each LED step stays lit.
- `OFF_TICKS`, 2: number of `tick` strobes of dark gap before each step.
- `TIMEOUT_TICKS`, 32: number of `tick` strobes with no press in INPUT before the game is lost.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `seed`  in  8  counter value; sampled only on an accepted `start`.
- `start`  in  1  level input; sampled in IDLE/WIN/LOSE only.
- `tick`  in  1  single-cycle timebase strobe.
- `btn`  in  4  debounced button levels, one bit per colour.
- `led`  out  4  one-hot colour display; 0 means dark.
- `level`  out  5  current round, which equals the sequence length.
- `busy`  out  1  high in SHOW_OFF, SHOW_ON and INPUT.
- `win`  out  1  high while in WIN.
- `lose`  out  1  high while in LOSE.

## Operation
- **States:** IDLE, SHOW_OFF, SHOW_ON, INPUT, WIN, LOSE.
- **Registered outputs:** all outputs are registered. They are valid in the first cycle of each state.
- **Reset values:**
  - state = IDLE.
  - `led`, `level`, `busy`, `win`, `lose` = 0.
  - `lfsr`, `seed_r`, index, tick counter and `btn_q` = 0.
- **Start:**
  - Accepted only in IDLE, WIN or LOSE.
  - Sets `seed_r` = `seed`, or 8'h01 if `seed` is 0.
  - Sets `level` = 1, index = 0, `lfsr` = `seed_r`.
  - Clears `win` and `lose`, then enters SHOW_OFF.
  - `start` in any other state is ignored.
- **LFSR:**
  - Next value = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Colour of step k is bits [1:0] of the LFSR after k shifts from `seed_r`.
  - The LFSR is reloaded from `seed_r` at the start of every playback and every input phase, so each round replays the same prefix.
- **SHOW_OFF:**
  - `led` = 0.
  - After `OFF_TICKS` ticks, enters SHOW_ON.
- **SHOW_ON:**
  - `led` = 1 << lfsr[1:0].
  - After `ON_TICKS` ticks, shifts the LFSR and increments index.
  - If the new index equals `level`: enters INPUT with index = 0 and the LFSR reloaded.
  - Otherwise: returns to SHOW_OFF.
- **Button edges:** press = `btn` & ~`btn_q`, with `btn_q` registered every cycle. Presses outside INPUT are ignored.
- **INPUT:**
  - `led` follows `btn`, registered one cycle later.
  - Press with exactly one bit set that equals 1 << lfsr[1:0] is correct: shift the LFSR, increment index, clear the timeout counter.
  - Correct press on the last step (index = `level`-1):
    - If `level` == `MAX_LEN`: enter WIN.
    - Otherwise: `level`+1, index = 0, LFSR reloaded, enter SHOW_OFF.
  - Wrong colour, or two or more bits rising in the same cycle, enters LOSE.
  - `TIMEOUT_TICKS` ticks without a correct press enters LOSE.
- **WIN / LOSE:**
  - `led` = 4'b1111 on win, 0 on lose.
  - `level` holds its final value.
  - The state is held until an accepted `start`.
- **Tick counter:**
  - Cleared on every state entry.
  - A `tick` in the entry cycle counts.
  - A phase of N ticks ends on the edge that samples the N-th tick.
- **Reset mid-operation:** `rst_n` low on any edge forces all reset values on that edge, regardless of state.

## Timing
- **Start to playback:** `start` sampled at edge E → SHOW_OFF and `busy` = 1 visible after E. The first LED lights after edge `OFF_TICKS` ticks later.
- **Round 1 cost:** one step costs (`OFF_TICKS` + `ON_TICKS`) ticks before INPUT.
- **Press latency:** a button rising at edge E is detected at edge E+1. The state and LED change are visible after E+1.
- **Simultaneous events:**
  - A press in the same cycle as the timeout's final tick counts as a correct press, so timeout loses priority.
  - `rst_n` takes priority over everything.
- **Level width:** the `level` increment never exceeds `MAX_LEN`, so no wrap-around occurs.

## Test plan
- **Seed 0 substitution:** `seed`=8'h00 and `start`, `OFF_TICKS`=2, `ON_TICKS`=4 → `seed_r`=8'h01 and `level`=1. `led` = 0 for 2 ticks, then 4'b0010 for 4 ticks. INPUT is entered with `led` = 0.
- **Three-round sequence:** `seed`=8'h01; in each INPUT press the correct buttons → the round-3 playback is 4'b0010, 4'b0100, 4'b0001 and `level`=3 during it.
- **Wrong press:** in round 1 press 4'b0001 instead of 4'b0010 → LOSE one cycle after detection; `lose`=1, `busy`=0, `level`=1.
- **Illegal and stale presses:** 4'b0011 rising in the same cycle → LOSE. A press during SHOW_ON → ignored, and `level` is unchanged.
- **Timeout:** no press for 32 ticks in INPUT → LOSE. One correct press at tick 31 clears the counter and the game continues.
- **Win, restart, reset:**
  - `MAX_LEN`=2: finish both rounds → `win`=1 and `led`=4'b1111.
  - `start` from WIN → new game with `level`=1.
  - `rst_n`=0 mid-SHOW_ON → all outputs 0 on the next edge.

Source files
------------

// File: rtl/simon_game_core.sv
// simon_game_core: Simon Says engine; seeds an LFSR colour sequence, plays it on four LEDs, judges presses.
// Latency: all outputs registered; a button rising is judged one edge later; phases end on the edge sampling their last tick.
// Backpressure: none; tick paces playback and timeout, presses outside INPUT and start while busy are dropped.
module simon_game_core #(
    parameter int MAX_LEN       = 16,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [4:0] level,
    output logic       busy,
    output logic       win,
    output logic       lose
);
    // Tick counter must hold the longest phase length of the three.
    localparam int TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX   = (TIMEOUT_TICKS > TMAX_A) ? TIMEOUT_TICKS : TMAX_A;
    localparam int CW     = $clog2(TMAX + 1);

    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
    localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW_OFF = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_INPUT    = 3'd3,
        S_WIN      = 3'd4,
        S_LOSE     = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [7:0]      lfsr, lfsr_n;
    logic [7:0]      seed_r, seed_r_n;
    logic [4:0]      idx, idx_n;
    logic [4:0]      level_n;
    logic [CW-1:0]   tick_cnt, tick_cnt_n;
    logic [3:0]      btn_q;
    logic [3:0]      led_n;
    logic            busy_n, win_n, lose_n;

    logic [7:0]      lfsr_step;
    logic [3:0]      press;
    logic [3:0]      exp_col;
    logic [CW-1:0]   tick_cnt_inc;

    assign lfsr_step    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign press        = btn & ~btn_q;
    assign exp_col      = 4'b0001 << lfsr[1:0];
    assign tick_cnt_inc = tick ? tick_cnt + CW'(1) : tick_cnt;

    // State and datapath registers; outputs are registered from their next values so they are valid on state entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lfsr     <= 8'h00;
            seed_r   <= 8'h00;
            idx      <= 5'd0;
            tick_cnt <= '0;
            btn_q    <= 4'b0000;
            level    <= 5'd0;
            led      <= 4'b0000;
            busy     <= 1'b0;
            win      <= 1'b0;
            lose     <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            seed_r   <= seed_r_n;
            idx      <= idx_n;
            tick_cnt <= tick_cnt_n;
            btn_q    <= btn;
            level    <= level_n;
            led      <= led_n;
            busy     <= busy_n;
            win      <= win_n;
            lose     <= lose_n;
        end
    end

    // Next state plus sequence datapath; tick counter restarts at zero on every state change.
    always_comb begin
        state_n    = state;
        lfsr_n     = lfsr;
        seed_r_n   = seed_r;
        idx_n      = idx;
        level_n    = level;
        tick_cnt_n = '0;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    // A zero seed would lock the LFSR, so it is replaced by 1.
                    seed_r_n = (seed == 8'h00) ? 8'h01 : seed;
                    lfsr_n   = seed_r_n;
                    level_n  = 5'd1;
                    idx_n    = 5'd0;
                    state_n  = S_SHOW_OFF;
                end
            end
            S_SHOW_OFF: begin
                if (tick && tick_cnt == OFF_LAST) begin
                    state_n = S_SHOW_ON;
                end else begin
                    tick_cnt_n = tick_cnt_inc;
                end
            end
            S_SHOW_ON: begin
                if (tick && tick_cnt == ON_LAST) begin
                    idx_n  = idx + 5'd1;
                    lfsr_n = lfsr_step;
                    if (idx_n == level) begin
                        // Playback done: rewind the sequence for the player.
                        idx_n   = 5'd0;
                        lfsr_n  = seed_r;
                        state_n = S_INPUT;
                    end else begin
                        state_n = S_SHOW_OFF;
                    end
                end else begin
                    tick_cnt_n = tick_cnt_inc;
                end
            end
            S_INPUT: begin
                // Any rising edge is judged before the timeout, so a press on the final tick still counts.
                if (press != 4'b0000) begin
                    // exp_col is one-hot, so equality also rejects multi-bit presses.
                    if (press == exp_col) begin
                        lfsr_n = lfsr_step;
                        idx_n  = idx + 5'd1;
                        if (idx == level - 5'd1) begin
                            if (level == LEN_MAX) begin
                                state_n = S_WIN;
                            end else begin
                                level_n = level + 5'd1;
                                idx_n   = 5'd0;
                                lfsr_n  = seed_r;
                                state_n = S_SHOW_OFF;
                            end
                        end
                    end else begin
                        state_n = S_LOSE;
                    end
                end else if (tick && tick_cnt == TO_LAST) begin
                    state_n = S_LOSE;
                end else begin
                    tick_cnt_n = tick_cnt_inc;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so each state shows them from its first cycle.
    always_comb begin
        led_n = 4'b0000;
        case (state_n)
            S_SHOW_ON: led_n = 4'b0001 << lfsr_n[1:0];
            // Entering INPUT shows dark; afterwards the LEDs echo the buttons one cycle late.
            S_INPUT:   led_n = (state == S_INPUT) ? btn : 4'b0000;
            S_WIN:     led_n = 4'b1111;
            default:   led_n = 4'b0000;
        endcase
        busy_n = (state_n == S_SHOW_OFF) || (state_n == S_SHOW_ON) || (state_n == S_INPUT);
        win_n  = (state_n == S_WIN);
        lose_n = (state_n == S_LOSE);
    end
endmodule

// File: tb/tb_simon_game_core.sv
// Bench for simon_game_core: table of round-1 press outcomes plus hand-written multi-round, timeout, win and reset sequences.
// Playback colours are queued when a round is started and checked by a monitor as each lit step ends.
// Ticks are strobed every third cycle; inputs are driven 1 time unit after the rising edge.
module tb_simon_game_core;
    localparam int OFF = 2;
    localparam int ON  = 4;
    localparam int TO  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seed;
    logic       start;
    logic       tick;
    logic [3:0] btn;

    logic [3:0] led, led2;
    logic [4:0] level, level2;
    logic       busy, win, lose;
    logic       busy2, win2, lose2;

    int checks = 0;
    int errors = 0;

    logic       mon_en = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] seg_led;
    int         seg_ticks;
    int         seg_gap;
    int         gap_ticks;

    typedef struct {
        logic [7:0] seed;
        logic [3:0] press;
        logic       exp_lose;
        logic       exp_busy;
        logic [4:0] exp_level;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    simon_game_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (seed),
        .start (start),
        .tick  (tick),
        .btn   (btn),
        .led   (led),
        .level (level),
        .busy  (busy),
        .win   (win),
        .lose  (lose)
    );

    simon_game_core #(.MAX_LEN(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (seed),
        .start (start),
        .tick  (tick),
        .btn   (btn),
        .led   (led2),
        .level (level2),
        .busy  (busy2),
        .win   (win2),
        .lose  (lose2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Colour of step k for an effective seed, straight from the sequence definition.
    function automatic logic [3:0] colour(input logic [7:0] eff, input int k);
        logic [7:0] v;
        logic [3:0] one;
        v = eff;
        for (int j = 0; j < k; j++) v = lfsr_next(v);
        one = 4'b0001;
        return one << v[1:0];
    endfunction

    function automatic logic [7:0] eff_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(2);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        seed   = 8'h00;
        start  = 1'b0;
        tick   = 1'b0;
        btn    = 4'b0000;
        mon_en = 1'b0;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic start_game(input logic [7:0] s);
        seed  = s;
        start = 1'b1;
        step(1);
        start = 1'b0;
        seed  = 8'h00;
        chk("start_busy", busy, 1);
        chk("start_level", level, 1);
    endtask

    task automatic push_round(input logic [7:0] eff, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(colour(eff, k));
    endtask

    // Runs a whole playback of n steps; queued colours must be consumed and INPUT entered dark.
    task automatic run_playback(input int n);
        chk("play_level", level, n);
        mon_en = 1'b1;
        tick_n(n * (OFF + ON));
        step(2);
        chk("play_drain", exp_q.size(), 0);
        chk("input_led", led, 0);
        chk("input_busy", busy, 1);
        mon_en = 1'b0;
    endtask

    // Presses the n correct colours of the current round.
    task automatic press_round(input logic [7:0] eff, input int n);
        logic [3:0] c;
        for (int k = 0; k < n; k++) begin
            c   = colour(eff, k);
            btn = c;
            step(1);
            if (k < n - 1) begin
                chk("in_led_follow", led, c);
                chk("in_busy", busy, 1);
            end else begin
                chk("round_next_level", level, n + 1);
                chk("round_next_led", led, 0);
            end
            btn = 4'b0000;
            step(1);
        end
    endtask

    // Each lit playback step is checked against the queue when it goes dark.
    always @(negedge clk) begin
        if (!mon_en) begin
            seg_led   = 4'b0000;
            seg_ticks = 0;
            seg_gap   = 0;
            gap_ticks = 0;
        end else begin
            if (led != seg_led) begin
                if (seg_led != 4'b0000) begin
                    chk("seg_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        chk("seg_colour", seg_led, exp_q.pop_front());
                        chk("seg_on_ticks", seg_ticks, ON);
                        chk("seg_off_ticks", seg_gap, OFF);
                    end
                end
                seg_led   = led;
                seg_ticks = 0;
                seg_gap   = gap_ticks;
                gap_ticks = 0;
            end
            if (tick) begin
                if (seg_led != 4'b0000) seg_ticks++;
                else gap_ticks++;
            end
        end
    end

    initial begin
        logic [7:0] eff;

        tbl[0] = '{8'h00, 4'b0010, 1'b0, 1'b1, 5'd2};
        tbl[1] = '{8'h01, 4'b0001, 1'b1, 1'b0, 5'd1};
        tbl[2] = '{8'h01, 4'b0011, 1'b1, 1'b0, 5'd1};
        tbl[3] = '{8'h03, 4'b1000, 1'b0, 1'b1, 5'd2};
        tbl[4] = '{8'h02, 4'b0100, 1'b0, 1'b1, 5'd2};
        tbl[5] = '{8'h02, 4'b0110, 1'b1, 1'b0, 5'd1};
        tbl[6] = '{8'hFC, 4'b0001, 1'b0, 1'b1, 5'd2};
        tbl[7] = '{8'hFC, 4'b1000, 1'b1, 1'b0, 5'd1};

        // Reset values.
        do_reset();
        chk("rst_led", led, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);

        // Round-1 press outcomes, including seed 0 substitution and two-bit presses.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            start_game(tbl[i].seed);
            eff = eff_seed(tbl[i].seed);
            push_round(eff, 1);
            run_playback(1);
            btn = tbl[i].press;
            step(1);
            chk($sformatf("vec%0d_lose", i), lose, tbl[i].exp_lose);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("vec%0d_level", i), level, tbl[i].exp_level);
            chk($sformatf("vec%0d_led", i), led, 0);
            btn = 4'b0000;
            step(1);
        end

        // Three rounds from seed 1; round 3 must replay 0010, 0100, 0001.
        do_reset();
        start_game(8'h01);
        push_round(8'h01, 1);
        run_playback(1);
        press_round(8'h01, 1);
        push_round(8'h01, 2);
        run_playback(2);
        press_round(8'h01, 2);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0001);
        run_playback(3);

        // A press during SHOW_ON is ignored and does not count toward the input phase.
        do_reset();
        start_game(8'h01);
        exp_q.push_back(4'b0010);
        mon_en = 1'b1;
        tick_n(OFF);
        chk("stale_on_led", led, 4'b0010);
        btn = 4'b0010;
        step(1);
        btn = 4'b0000;
        step(1);
        chk("stale_level", level, 1);
        chk("stale_busy", busy, 1);
        chk("stale_lose", lose, 0);
        chk("stale_led", led, 4'b0010);
        tick_n(ON);
        step(2);
        chk("stale_drain", exp_q.size(), 0);
        chk("stale_input_led", led, 0);
        mon_en = 1'b0;
        press_round(8'h01, 1);

        // Timeout after a full window of silence.
        do_reset();
        start_game(8'h01);
        push_round(8'h01, 1);
        run_playback(1);
        tick_n(TO - 1);
        chk("to_early_busy", busy, 1);
        chk("to_early_lose", lose, 0);
        tick_n(1);
        chk("to_lose", lose, 1);
        chk("to_busy", busy, 0);
        chk("to_level", level, 1);

        // Correct press on the final timeout tick wins the tie.
        do_reset();
        start_game(8'h01);
        push_round(8'h01, 1);
        run_playback(1);
        tick_n(TO - 1);
        tick = 1'b1;
        btn  = 4'b0010;
        step(1);
        tick = 1'b0;
        btn  = 4'b0000;
        chk("tie_level", level, 2);
        chk("tie_lose", lose, 0);
        chk("tie_busy", busy, 1);
        step(1);

        // A correct mid-round press restarts the timeout window.
        push_round(8'h01, 2);
        run_playback(2);
        tick_n(TO - 1);
        btn = 4'b0010;
        step(1);
        btn = 4'b0000;
        step(1);
        chk("clr_busy", busy, 1);
        tick_n(TO - 1);
        chk("clr_busy_late", busy, 1);
        chk("clr_lose_late", lose, 0);
        tick_n(1);
        chk("clr_lose", lose, 1);

        // Win with MAX_LEN=2, restart from WIN, then reset during SHOW_ON.
        do_reset();
        start_game(8'h01);
        push_round(8'h01, 1);
        run_playback(1);
        press_round(8'h01, 1);
        push_round(8'h01, 2);
        run_playback(2);
        press_round(8'h01, 2);
        chk("win_win", win2, 1);
        chk("win_led", led2, 4'b1111);
        chk("win_busy", busy2, 0);
        chk("win_lose", lose2, 0);
        chk("win_level", level2, 2);
        seed  = 8'h05;
        start = 1'b1;
        step(1);
        start = 1'b0;
        seed  = 8'h00;
        chk("restart_level", level2, 1);
        chk("restart_win", win2, 0);
        chk("restart_busy", busy2, 1);
        chk("busy_start_ignored", level, 3);
        tick_n(OFF);
        chk("restart_led", led2, colour(8'h05, 0));
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_led", led2, 0);
        chk("mid_rst_level", level2, 0);
        chk("mid_rst_busy", busy2, 0);
        chk("mid_rst_win", win2, 0);
        chk("mid_rst_lose", lose2, 0);
        chk("mid_rst_level_main", level, 0);
        chk("mid_rst_busy_main", busy, 0);
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
